// File: rtl/usbfs_endp_tx.sv
// USB full-speed IN endpoint adapter: buffers user bytes in a FIFO, packetizes them
// (full packet or idle timeout) and copies each packet into the transmit transactor buffer.
module usbfs_endp_tx #(
    parameter int MAX_PKT      = 8,
    parameter int FLUSH_CYCLES = 16,
    localparam int IDX_W       = $clog2(MAX_PKT),
    localparam int NBYTES_W    = $clog2(MAX_PKT + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [7:0]          i_data,
    output logic                o_etValid,
    input  logic                i_etReady,
    output logic                o_etStall,
    output logic                o_etWrEn,
    output logic [IDX_W-1:0]    o_etWrIdx,
    output logic [7:0]          o_etWrByte,
    output logic [NBYTES_W-1:0] o_etWrNBytes
);

    // A zero flush timeout still needs a one-bit counter that simply never leaves zero.
    localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0]    FLUSH_V = CNT_W'(FLUSH_CYCLES);
    localparam logic [NBYTES_W-1:0] MAX_V   = NBYTES_W'(MAX_PKT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_mem [MAX_PKT];
    logic [IDX_W-1:0]      r_wr_ptr;
    logic [IDX_W-1:0]      r_rd_ptr;
    logic [NBYTES_W-1:0]   r_count;
    logic [CNT_W-1:0]      r_idle;
    logic [IDX_W-1:0]      r_wr_idx;
    logic [NBYTES_W-1:0]   r_n_load;
    logic [NBYTES_W-1:0]   r_nbytes;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_start;
    logic                  w_last;
    logic                  w_wr_en;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [7:0]            w_wr_byte;
    logic                  w_et_valid;

    assign w_full  = (r_count == MAX_V);
    assign w_empty = (r_count == {NBYTES_W{1'b0}});
    assign w_push  = i_valid && !w_full;
    assign w_pop   = (r_state == ST_LOAD);
    assign w_start = (r_state == ST_IDLE) && !w_empty && (w_full || (r_idle == FLUSH_V));
    assign w_last  = (NBYTES_W'(r_wr_idx) == (r_n_load - NBYTES_W'(1)));

    // FIFO storage; contents are only observed through the head while loading, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because MAX_PKT is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {IDX_W{1'b0}};
            r_rd_ptr <= {IDX_W{1'b0}};
            r_count  <= {NBYTES_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + IDX_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + IDX_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + NBYTES_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - NBYTES_W'(1);
            end else begin
                r_count <= r_count;
            end
        end
    end

    // Idle timer: counts no-push cycles while data is waiting, saturating at the flush limit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idle <= {CNT_W{1'b0}};
        end else if (w_push || w_empty) begin
            r_idle <= {CNT_W{1'b0}};
        end else if (r_idle != FLUSH_V) begin
            r_idle <= r_idle + CNT_W'(1);
        end else begin
            r_idle <= r_idle;
        end
    end

    // Packet bookkeeping: length snapshot at packet start, write index, published length.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_idx <= {IDX_W{1'b0}};
            r_n_load <= {NBYTES_W{1'b0}};
            r_nbytes <= {NBYTES_W{1'b0}};
        end else if (w_start) begin
            r_wr_idx <= {IDX_W{1'b0}};
            r_n_load <= r_count;
            r_nbytes <= r_nbytes;
        end else if (r_state == ST_LOAD) begin
            r_wr_idx <= r_wr_idx + IDX_W'(1);
            r_n_load <= r_n_load;
            r_nbytes <= w_last ? r_n_load : r_nbytes;
        end else begin
            r_wr_idx <= r_wr_idx;
            r_n_load <= r_n_load;
            r_nbytes <= r_nbytes;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and buffer-write decode; outputs depend only on registered state.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_idx    = {IDX_W{1'b0}};
        w_wr_byte   = 8'h00;
        w_et_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = r_wr_idx;
                w_wr_byte = r_mem[r_rd_ptr];
                if (w_last) begin
                    w_state_nxt = ST_ARMED;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_ARMED: begin
                w_et_valid = 1'b1;
                if (i_etReady) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ARMED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_ready      = !w_full;
    assign o_etValid    = w_et_valid;
    assign o_etStall    = 1'b0;
    assign o_etWrEn     = w_wr_en;
    assign o_etWrIdx    = w_wr_idx;
    assign o_etWrByte   = w_wr_byte;
    assign o_etWrNBytes = r_nbytes;

endmodule

// File: doc/usbfs_endp_tx.md
# usbfs_endp_tx

Device-to-host (IN) endpoint adapter for the USB full-speed device stack. It accepts a byte stream from user logic over a valid/ready handshake and buffers it in an internal FIFO. It packetizes the buffered bytes (full packet or idle timeout) and copies each packet, one byte per cycle, into the transmit transactor's packet buffer. It then presents the packet to the transactor as valid until the transactor reports successful transmission.

## Interface
- MAX_PKT, 8, maximum payload bytes per packet and internal FIFO depth; one of 8, 16, 32, 64.
- FLUSH_CYCLES, 16, consecutive no-push cycles after which a partial packet is sent; 0 means send as soon as non-empty.
- Derived widths: IDX_W = $clog2(MAX_PKT), NBYTES_W = $clog2(MAX_PKT+1).

Ports:
- i_clk  input  1  clock; single clock domain.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_valid  input  1  user byte valid.
- o_ready  output  1  endpoint can accept a user byte.
- i_data  input  8  user byte.
- o_etValid  output  1  a complete packet is loaded in the transactor buffer and is ready to send.
- i_etReady  input  1  transactor has sent the packet and the host ACKed it; the buffer is free.
- o_etStall  output  1  endpoint halted; tied 0.
- o_etWrEn  output  1  write strobe into transactor buffer.
- o_etWrIdx  output  IDX_W  byte index being written.
- o_etWrByte  output  8  byte being written.
- o_etWrNBytes  output  NBYTES_W  payload length of the loaded packet.

## Operation
- User push: push = i_valid && o_ready. o_ready = !full. There is no bypass: a full FIFO refuses a byte even while popping.
- Transactor accept: et_acc = o_etValid && i_etReady.
- idleCnt register, width $clog2(FLUSH_CYCLES+1):
  - Cleared on push or when the FIFO is empty.
  - Otherwise increments and saturates at FLUSH_CYCLES.
- FSM states: IDLE, LOAD, ARMED.
- IDLE -> LOAD when nEntries != 0 and (nEntries == MAX_PKT or idleCnt == FLUSH_CYCLES).
  - On this transition, latch nLoad = nEntries as it is in that cycle. A push accepted in the same cycle is excluded.
  - Also on this transition, clear the write index wrIdx.
- LOAD, once per cycle:
  - o_etWrEn = 1, o_etWrIdx = wrIdx, o_etWrByte = FIFO head.
  - Pop the FIFO and increment wrIdx.
- LOAD -> ARMED on the cycle with wrIdx == nLoad-1. o_etWrNBytes <= nLoad on this edge.
- Bytes pushed during LOAD or ARMED stay in the FIFO for the next packet.
- ARMED:
  - o_etValid = 1 and o_etWrEn = 0.
  - o_etWrNBytes is stable.
  - The buffer must not be written.
- ARMED -> IDLE on et_acc. A NAKed or retried transmission is handled by the transactor; the endpoint holds its state.
- o_etWrEn, o_etWrIdx and o_etWrByte are don't-care-free: in IDLE and ARMED, o_etWrEn = 0, and o_etWrIdx and o_etWrByte drive 0.
- No zero-length packets are generated. o_etWrNBytes is always between 1 and MAX_PKT whenever o_etValid = 1.
- o_etStall = 0 always.

## Timing
- Reset values:
  - State IDLE, FIFO empty, idleCnt = 0, wrIdx = 0, nLoad = 0.
  - o_ready = 1, o_etValid = 0, o_etWrEn = 0, o_etWrIdx = 0, o_etWrByte = 0, o_etWrNBytes = 0.
- Asserting i_rst_n low mid-LOAD or mid-ARMED discards the FIFO contents and the armed packet immediately (asynchronously). No o_etWrEn is issued after reset deasserts until a new packet forms.
- o_ready updates the cycle after a push that fills the FIFO.
- o_ready reasserts the cycle after the first LOAD pop.
- LOAD lasts exactly nLoad cycles, one write per cycle. o_etValid rises in the cycle after the last write.
- Latency example with FLUSH_CYCLES = 0: a byte pushed at edge e gives LOAD at edge e+1, the write in cycle e+1, and o_etValid from edge e+2.
- o_etValid falls in the cycle after et_acc. The earliest next LOAD is the cycle after that.
- i_etReady while o_etValid = 0 is ignored.

## Test plan
- MAX_PKT=8, FLUSH_CYCLES=4: push 0x00..0x07 back-to-back.
  - o_ready low after the 8th push.
  - 8 LOAD cycles with o_etWrIdx 0..7 and o_etWrByte 0x00..0x07.
  - o_etValid = 1 with o_etWrNBytes = 8.
  - An i_etReady pulse drops o_etValid the next cycle.
- Push 0xA1, 0xA2, 0xA3, then hold i_valid low.
  - LOAD starts 4 cycles after the last push.
  - 3 writes, o_etWrNBytes = 3.
- While ARMED with 3 bytes and i_etReady held 0, push 8 more bytes.
  - FIFO fills and o_ready goes low.
  - No o_etWrEn is issued.
  - After et_acc, an 8-byte packet loads with the correct bytes.
- Push during LOAD: 5 bytes are loading and a push of 0xFF occurs in the 2nd LOAD cycle.
  - The packet has o_etWrNBytes = 5.
  - 0xFF appears at index 0 of the next packet.
- Drive i_rst_n low in the 3rd LOAD cycle.
  - All outputs go to reset values immediately.
  - After release, no o_etValid until new pushes arrive.
- FLUSH_CYCLES=0: single push of 0x5A.
  - o_etWrEn in cycle e+1 with index 0 and byte 0x5A.
  - o_etValid from e+2 with o_etWrNBytes = 1.
